instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 23 ++
 rtl/instr_encoder.sv | 139 +++++++++++++
 tb/tb_instr_encoder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I immediate encoder.
// Master drives requests and consumes results; slave is the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  immsrc;
  logic [31:0] base;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        range_err;

  modport master (
    output in_valid, immsrc, base, imm, out_ready,
    input  in_ready, out_valid, instr, range_err
  );

  modport slave (
    input  in_valid, immsrc, base, imm, out_ready,
    output in_ready, out_valid, instr, range_err
  );
endinterface

// File: rtl/instr_encoder.sv
// Merges an immediate into an RV32I template; LI expands to LUI+ADDI.
// Optional range check enabled by macro INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder (
  input  logic                 clk,
  input  logic                 reset,
  instr_encoder_if.slave       bus
);

  typedef enum logic {IDLE, LI_LO} state_e;

  localparam logic [2:0] SRC_I  = 3'b000;
  localparam logic [2:0] SRC_S  = 3'b001;
  localparam logic [2:0] SRC_B  = 3'b010;
  localparam logic [2:0] SRC_U  = 3'b011;
  localparam logic [2:0] SRC_J  = 3'b100;
  localparam logic [2:0] SRC_LI = 3'b101;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_e      state_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] lo_q;

  logic [31:0] enc_d;
  logic [31:0] lo_d;
  logic        long_d;
  logic [4:0]  rd;
  logic        fits12;
  logic [19:0] lui_hi;
  logic        accept;
  logic        err_d;

  assign rd     = bus.base[11:7];
  assign fits12 = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  // Round the upper part so the signed low ADDI restores the value.
  assign lui_hi = bus.imm[31:12] + {19'd0, bus.imm[11]};

  assign bus.in_ready = !reset && state_q == IDLE &&
                        (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Immediate scatter for each format, plus LI expansion.
  always_comb begin
    enc_d  = bus.base;
    long_d = 1'b0;
    lo_d   = {bus.imm[11:0], rd, 3'b000, rd, OP_IMM};
    unique case (bus.immsrc)
      SRC_I: enc_d = {bus.imm[11:0], bus.base[19:0]};
      SRC_S: enc_d = {bus.imm[11:5], bus.base[24:12],
                      bus.imm[4:0], bus.base[6:0]};
      SRC_B: enc_d = {bus.imm[12], bus.imm[10:5], bus.base[24:12],
                      bus.imm[4:1], bus.imm[11], bus.base[6:0]};
      SRC_U: enc_d = {bus.imm[31:12], bus.base[11:0]};
      SRC_J: enc_d = {bus.imm[20], bus.imm[10:1], bus.imm[11],
                      bus.imm[19:12], bus.base[11:0]};
      SRC_LI: begin
        if (fits12) begin
          enc_d = {bus.imm[11:0], 5'd0, 3'b000, rd, OP_IMM};
        end else begin
          enc_d  = {lui_hi, rd, OP_LUI};
          long_d = 1'b1;
        end
      end
      default: enc_d = bus.base;
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic err_q;
  logic fits13;
  logic fits21;

  assign fits13 = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
  assign fits21 = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

  // Flag immediates the chosen format cannot represent.
  always_comb begin
    err_d = 1'b0;
    unique case (bus.immsrc)
      SRC_I, SRC_S: err_d = !fits12;
      SRC_B:  err_d = !fits13 || bus.imm[0];
      SRC_U:  err_d = |bus.imm[11:0];
      SRC_J:  err_d = !fits21 || bus.imm[0];
      SRC_LI: err_d = 1'b0;
      default: err_d = 1'b1;
    endcase
  end

  assign bus.range_err = err_q;
`else
  assign err_d         = 1'b0;
  assign bus.range_err = 1'b0;
`endif

  // Output register and LI sequencing FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      lo_q    <= '0;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            valid_q <= 1'b1;
            instr_q <= enc_d;
            lo_q    <= lo_d;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
            if (long_d) state_q <= LI_LO;
          end else if (bus.out_ready) begin
            valid_q <= 1'b0;
          end
        end
        LI_LO: begin
          if (bus.out_ready) begin
            instr_q <= lo_q;
            state_q <= IDLE;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.instr     = instr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized check of instr_encoder against a queue-based reference.
// Directed cases cover the documented encodings, LI, stall and reset.
module tb_instr_encoder;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [32:0] q[$];

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: mask out immediate slots, OR in shifted fields.
  function automatic void model(input logic [2:0] src,
                                input logic [31:0] b,
                                input logic [31:0] i);
    logic [31:0] mask;
    logic [31:0] f;
    logic [31:0] rd;
    logic [31:0] hi;
    logic        err;
    int          si;
    si   = $signed(i);
    mask = 0;
    f    = 0;
    err  = 0;
    rd   = (b >> 7) & 32'h1F;
    case (src)
      3'd0: begin
        mask = 32'hFFF00000;
        f    = (i & 32'hFFF) << 20;
        err  = si < -2048 || si > 2047;
      end
      3'd1: begin
        mask = 32'hFE000F80;
        f    = (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
        err  = si < -2048 || si > 2047;
      end
      3'd2: begin
        mask = 32'hFE000F80;
        f    = (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25)
             | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7);
        err  = si < -4096 || si > 4094 || (i & 1) != 0;
      end
      3'd3: begin
        mask = 32'hFFFFF000;
        f    = i & 32'hFFFFF000;
        err  = (i & 32'hFFF) != 0;
      end
      3'd4: begin
        mask = 32'hFFFFF000;
        f    = (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21)
             | (((i >> 11) & 1) << 20) | (((i >> 12) & 32'hFF) << 12);
        err  = si < -(1 << 20) || si > (1 << 20) - 2 || (i & 1) != 0;
      end
      3'd5: begin
        if (si >= -2048 && si <= 2047) begin
          q.push_back({1'b0, ((i & 32'hFFF) << 20) | (rd << 7) | 32'h13});
        end else begin
          hi = (i + 32'h800) & 32'hFFFFF000;
          q.push_back({1'b0, hi | (rd << 7) | 32'h37});
          q.push_back({1'b0, ((i & 32'hFFF) << 20) | (rd << 15)
                             | (rd << 7) | 32'h13});
        end
        return;
      end
      default: err = 1;
    endcase
    q.push_back({err & RC, (b & ~mask) | f});
  endfunction

  // One clock: drive, compare against the model, advance the model.
  task automatic cycle(input logic rst, input logic v,
                       input logic [2:0] src, input logic [31:0] b,
                       input logic [31:0] i, input logic ordy);
    logic exp_rdy;
    logic acc;
    reset         = rst;
    bus.in_valid  = v;
    bus.immsrc    = src;
    bus.base      = b;
    bus.imm       = i;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !rst && (q.size() == 0 || (q.size() == 1 && ordy));
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("instr", bus.instr, q[0][31:0]);
      chk("range_err", {31'd0, bus.range_err}, {31'd0, q[0][32]});
    end
    acc = v && exp_rdy;
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (acc) model(src, b, i);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_instr", bus.instr, 32'd0);
      chk("rst_err", {31'd0, bus.range_err}, 32'd0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && q.size() != 0; k++)
      cycle(0, 0, 3'd0, 32'd0, 32'd0, 1);
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic req(input logic [2:0] src, input logic [31:0] b,
                     input logic [31:0] i);
    drain();
    cycle(0, 1, src, b, i, 1);
  endtask

  logic [31:0] held;
  logic [31:0] ri;

  initial begin
    reset         = 1;
    bus.in_valid  = 0;
    bus.immsrc    = 0;
    bus.base      = 0;
    bus.imm       = 0;
    bus.out_ready = 0;
    #1;
    cycle(1, 0, 3'd0, 32'd0, 32'd0, 0);
    cycle(1, 1, 3'd0, 32'd0, 32'd0, 1);

    req(3'd0, 32'h00000293, 32'hFFFFFFFF);
    chk("I_instr", bus.instr, 32'hFFF00293);
    chk("I_err", {31'd0, bus.range_err}, 32'd0);
    req(3'd1, 32'h00612023, 32'd8);
    chk("S_instr", bus.instr, 32'h00612423);
    req(3'd2, 32'h00000063, 32'd16);
    chk("B_instr", bus.instr, 32'h00000863);
    req(3'd4, 32'h000000EF, 32'h800);
    chk("J_instr", bus.instr, 32'h001000EF);

    req(3'd5, 32'h00000513, 32'h12345FFF);
    chk("LUI", bus.instr, 32'h12346537);
    chk("LI_rdy", {31'd0, bus.in_ready}, 32'd0);
    cycle(0, 1, 3'd0, 32'd0, 32'd0, 1);
    chk("ADDI", bus.instr, 32'hFFF50513);

    req(3'd5, 32'h00000513, 32'd5);
    chk("LI_short", bus.instr, 32'h00500513);

    req(3'd0, 32'h00000293, 32'd2048);
    chk("err_imm", {20'd0, bus.instr[31:20]}, 32'h800);
    chk("err_flag", {31'd0, bus.range_err}, {31'd0, RC});

    req(3'd3, 32'h000002B7, 32'hABCDE000);
    held = bus.instr;
    for (int k = 0; k < 3; k++) cycle(0, 1, 3'd0, 32'h13, 32'd1, 0);
    chk("stall_hold", bus.instr, held);

    req(3'd5, 32'h00000593, 32'h7FFFF800);
    cycle(1, 1, 3'd0, 32'd0, 32'd0, 1);
    for (int k = 0; k < 3; k++) cycle(0, 0, 3'd0, 32'd0, 32'd0, 1);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: ri = $urandom_range(0, 8191) - 32'd4096;
        1: ri = $urandom_range(0, 32'h3FFFFF) - 32'h200000;
        2: ri = $urandom & 32'hFFFFF000;
        default: ri = $urandom;
      endcase
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 7,
            3'($urandom_range(0, 7)),
            $urandom, ri,
            $urandom_range(0, 3) != 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
